fast_idct: RTL and testbench

- In-place 8×8 two-dimensional inverse DCT over 16-bit signed coefficients in external memory, using the integer Chen–Wang algorithm.
- Pass order: eight row passes, then eight column passes with clipping.
- Memory access: the block reads and writes memory through a dual-channel RAM master port.
- Control: `start_port` launches it; `done_port` reports completion.

---
 rtl/fast_idct_pkg.sv | 50 +++++
 rtl/fast_idct_if.sv | 28 ++
 rtl/fast_idct_1d.sv | 67 ++++++
 rtl/fast_idct.sv | 116 +++++++++++
 tb/tb_fast_idct.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fast_idct_pkg.sv
// Shared constants, types and helpers for the in-place 8x8 Chen-Wang inverse DCT.
package fast_idct_pkg;

  localparam logic signed [31:0] W1 = 32'sd2841;
  localparam logic signed [31:0] W2 = 32'sd2676;
  localparam logic signed [31:0] W3 = 32'sd2408;
  localparam logic signed [31:0] W5 = 32'sd1609;
  localparam logic signed [31:0] W6 = 32'sd1108;
  localparam logic signed [31:0] W7 = 32'sd565;
  localparam logic signed [31:0] C181 = 32'sd181;

  localparam logic signed [31:0] RND_128  = 32'sd128;
  localparam logic signed [31:0] RND_8192 = 32'sd8192;
  localparam logic signed [31:0] RND_4    = 32'sd4;

  localparam logic signed [31:0] CLIP_LO = -32'sd256;
  localparam logic signed [31:0] CLIP_HI = 32'sd255;

  localparam logic [4:0] ACC_SIZE = 5'd16;

  typedef logic signed [15:0] elem_t;
  typedef elem_t [7:0] line_t;

  typedef enum logic { MODE_ROW = 1'b0, MODE_COL = 1'b1 } pass_t;

  typedef enum logic [2:0] {
    IDLE, ROW_READ, ROW_CALC, ROW_WRITE, COL_READ, COL_CALC, COL_WRITE, DONE
  } state_t;

  function automatic logic signed [31:0] sx(input elem_t e);
    return {{16{e[15]}}, e};
  endfunction

  // Final scaling of a butterfly output: rows keep 16 bits, columns clip to 9-bit pixels.
  function automatic elem_t scale_out(input logic signed [31:0] v, input pass_t mode);
    logic signed [31:0] t;
    elem_t r;
    if (mode == MODE_COL) begin
      t = v >>> 14;
      if (t < CLIP_LO)      r = CLIP_LO[15:0];
      else if (t > CLIP_HI) r = CLIP_HI[15:0];
      else                  r = t[15:0];
    end else begin
      t = v >>> 8;
      r = t[15:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/fast_idct_if.sv
// Dual-channel RAM master bus plus an FSM state view for checkers.
interface fast_idct_if;
  import fast_idct_pkg::*;

  // Handshake: a channel's oe or we is held, with its address, data and size
  // stable, until M_DataRdy for that channel is 1 at a rising edge; the access
  // completes on that edge. oe and we are never both high on one channel.
  logic [31:0] M_Rdata_ram;
  logic [1:0]  M_DataRdy;
  logic [1:0]  Mout_oe_ram;
  logic [1:0]  Mout_we_ram;
  logic [63:0] Mout_addr_ram;
  logic [31:0] Mout_Wdata_ram;
  logic [9:0]  Mout_data_ram_size;
  state_t      dbg_state;

  modport master (
    input  M_Rdata_ram, M_DataRdy,
    output Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram,
           Mout_data_ram_size, dbg_state
  );

  modport slave (
    output M_Rdata_ram, M_DataRdy,
    input  Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram,
           Mout_data_ram_size, dbg_state
  );
endinterface

// File: rtl/fast_idct_1d.sv
// Combinational 8-point Chen-Wang butterfly; mode picks row or column scaling.
module fast_idct_1d
  import fast_idct_pkg::*;
(
  input  pass_t mode,
  input  line_t din,
  output line_t dout
);

  logic signed [31:0] x0, x1, x2, x3, x4, x5, x6, x7, x8;
  logic signed [31:0] rw;
  logic [1:0]         sh;

  always_comb begin
    dout = '0;
    // Row pass has no pre-rounding and no intermediate shift; column adds 4 then >>3.
    rw = (mode == MODE_COL) ? RND_4 : 32'sd0;
    sh = (mode == MODE_COL) ? 2'd3 : 2'd0;
    if (mode == MODE_COL) begin
      x0 = (sx(din[0]) <<< 8) + RND_8192;
      x1 = sx(din[4]) <<< 8;
    end else begin
      x0 = (sx(din[0]) <<< 11) + RND_128;
      x1 = sx(din[4]) <<< 11;
    end
    x2 = sx(din[6]);
    x3 = sx(din[2]);
    x4 = sx(din[1]);
    x5 = sx(din[7]);
    x6 = sx(din[5]);
    x7 = sx(din[3]);

    x8 = W7 * (x4 + x5) + rw;
    x4 = (x8 + (W1 - W7) * x4) >>> sh;
    x5 = (x8 - (W1 + W7) * x5) >>> sh;
    x8 = W3 * (x6 + x7) + rw;
    x6 = (x8 - (W3 - W5) * x6) >>> sh;
    x7 = (x8 - (W3 + W5) * x7) >>> sh;

    x8 = x0 + x1;
    x0 = x0 - x1;
    x1 = W6 * (x3 + x2) + rw;
    x2 = (x1 - (W2 + W6) * x2) >>> sh;
    x3 = (x1 + (W2 - W6) * x3) >>> sh;
    x1 = x4 + x6;
    x4 = x4 - x6;
    x6 = x5 + x7;
    x5 = x5 - x7;

    x7 = x8 + x3;
    x8 = x8 - x3;
    x3 = x0 + x2;
    x0 = x0 - x2;
    x2 = (C181 * (x4 + x5) + RND_128) >>> 8;
    x4 = (C181 * (x4 - x5) + RND_128) >>> 8;

    dout[0] = scale_out(x7 + x1, mode);
    dout[1] = scale_out(x3 + x2, mode);
    dout[2] = scale_out(x0 + x4, mode);
    dout[3] = scale_out(x8 + x6, mode);
    dout[4] = scale_out(x8 - x6, mode);
    dout[5] = scale_out(x0 - x4, mode);
    dout[6] = scale_out(x3 - x2, mode);
    dout[7] = scale_out(x7 - x1, mode);
  end

endmodule

// File: rtl/fast_idct.sv
// In-place 8x8 IDCT: eight row passes then eight column passes over external RAM.
module fast_idct
  import fast_idct_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start_port,
  input  logic [31:0] block,
  output logic        done_port,
  fast_idct_if.master mem
);

  state_t      state, state_next;
  logic [31:0] base;
  logic [2:0]  idx;
  logic [1:0]  beat;
  logic [1:0]  req;
  line_t       line, line_calc;
  pass_t       mode;
  logic        in_read, in_write, beat_done, last_beat;
  logic [5:0]  elem0, elem1;
  logic [31:0] addr0, addr1;
  logic [1:0]  active;

  assign in_read   = (state == ROW_READ)  || (state == COL_READ);
  assign in_write  = (state == ROW_WRITE) || (state == COL_WRITE);
  assign mode      = (state inside {COL_READ, COL_CALC, COL_WRITE}) ? MODE_COL : MODE_ROW;
  // A channel with no outstanding request counts as already complete.
  assign beat_done = &(~req | mem.M_DataRdy);
  assign last_beat = beat_done && (beat == 2'd3);

  assign elem0 = (mode == MODE_ROW) ? {idx, beat, 1'b0} : {beat, 1'b0, idx};
  assign elem1 = (mode == MODE_ROW) ? {idx, beat, 1'b1} : {beat, 1'b1, idx};
  assign addr0 = base + {25'd0, elem0, 1'b0};
  assign addr1 = base + {25'd0, elem1, 1'b0};

  fast_idct_1d u_1d (
    .mode (mode),
    .din  (line),
    .dout (line_calc)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (start_port) state_next = ROW_READ;
      ROW_READ:  if (last_beat) state_next = ROW_CALC;
      ROW_CALC:  state_next = ROW_WRITE;
      ROW_WRITE: if (last_beat) state_next = (idx == 3'd7) ? COL_READ : ROW_READ;
      COL_READ:  if (last_beat) state_next = COL_CALC;
      COL_CALC:  state_next = COL_WRITE;
      COL_WRITE: if (last_beat) state_next = (idx == 3'd7) ? DONE : COL_READ;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      base <= '0;
      idx  <= '0;
      beat <= '0;
      req  <= '0;
      line <= '0;
    end else begin
      case (state)
        IDLE: if (start_port) begin
          base <= block;
          idx  <= '0;
          beat <= '0;
          req  <= 2'b11;
        end
        ROW_CALC, COL_CALC: begin
          line <= line_calc;
          beat <= '0;
          req  <= 2'b11;
        end
        ROW_READ, COL_READ, ROW_WRITE, COL_WRITE: begin
          if (in_read && req[0] && mem.M_DataRdy[0]) line[{beat, 1'b0}] <= mem.M_Rdata_ram[15:0];
          if (in_read && req[1] && mem.M_DataRdy[1]) line[{beat, 1'b1}] <= mem.M_Rdata_ram[31:16];
          if (!beat_done) begin
            req <= req & ~mem.M_DataRdy;
          end else if (beat != 2'd3) begin
            beat <= beat + 2'd1;
            req  <= 2'b11;
          end else if (in_read) begin
            beat <= '0;
            req  <= 2'b00;
          end else begin
            // End of a line write: either start the next line or finish.
            beat <= '0;
            idx  <= idx + 3'd1;
            req  <= (state == COL_WRITE && idx == 3'd7) ? 2'b00 : 2'b11;
          end
        end
        default: ;
      endcase
    end
  end

  assign active                 = req & {2{in_read | in_write}};
  assign mem.Mout_oe_ram        = in_read  ? req : 2'b00;
  assign mem.Mout_we_ram        = in_write ? req : 2'b00;
  assign mem.Mout_addr_ram      = {active[1] ? addr1 : 32'd0, active[0] ? addr0 : 32'd0};
  assign mem.Mout_Wdata_ram     = {(in_write && req[1]) ? line[{beat, 1'b1}] : 16'sd0,
                                   (in_write && req[0]) ? line[{beat, 1'b0}] : 16'sd0};
  assign mem.Mout_data_ram_size = {active[1] ? ACC_SIZE : 5'd0, active[0] ? ACC_SIZE : 5'd0};
  assign mem.dbg_state          = state;
  assign done_port              = (state == DONE);

endmodule

// File: tb/tb_fast_idct.sv
// Directed bench for fast_idct: DC table, full reference vector, wait states, mid-run reset.
module tb_fast_idct;
  import fast_idct_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start_port = 1'b0;
  logic [31:0] block = 32'd0;
  logic        done_port;

  fast_idct_if mem_if ();

  fast_idct dut (
    .clock      (clock),
    .reset      (reset),
    .start_port (start_port),
    .block      (block),
    .done_port  (done_port),
    .mem        (mem_if)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- memory model ----------------
  logic [15:0] mem [256];
  logic [1:0]  wcnt [2] = '{default: 2'd0};
  logic [1:0]  act;
  logic [7:0]  a0, a1;
  logic        rand_wait = 1'b0;
  logic        ld_en = 1'b0;
  logic [7:0]  ld_addr = 8'd0;
  logic [15:0] ld_data = 16'd0;

  assign act = mem_if.Mout_oe_ram | mem_if.Mout_we_ram;
  assign a0  = mem_if.Mout_addr_ram[8:1];
  assign a1  = mem_if.Mout_addr_ram[40:33];
  assign mem_if.M_DataRdy   = {act[1] && (wcnt[1] == 2'd0), act[0] && (wcnt[0] == 2'd0)};
  assign mem_if.M_Rdata_ram = {mem_if.Mout_oe_ram[1] ? mem[a1] : 16'h0,
                               mem_if.Mout_oe_ram[0] ? mem[a0] : 16'h0};

  always @(posedge clock) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    if (act[0]) begin
      if (wcnt[0] == 2'd0) begin
        if (mem_if.Mout_we_ram[0]) mem[a0] <= mem_if.Mout_Wdata_ram[15:0];
        wcnt[0] <= rand_wait ? 2'($urandom_range(0, 3)) : 2'd0;
      end else wcnt[0] <= wcnt[0] - 2'd1;
    end
    if (act[1]) begin
      if (wcnt[1] == 2'd0) begin
        if (mem_if.Mout_we_ram[1]) mem[a1] <= mem_if.Mout_Wdata_ram[31:16];
        wcnt[1] <= rand_wait ? 2'($urandom_range(0, 3)) : 2'd0;
      end else wcnt[1] <= wcnt[1] - 2'd1;
    end
  end

  // ---------------- bus monitor ----------------
  logic [31:0] win_lo = 32'd0;
  int done_cnt = 0;
  int viol_cnt = 0;

  always @(negedge clock) begin
    if (done_port) done_cnt++;
    for (int ch = 0; ch < 2; ch++) begin
      logic [31:0] a;
      logic        on;
      a  = mem_if.Mout_addr_ram[ch*32 +: 32];
      on = mem_if.Mout_oe_ram[ch] | mem_if.Mout_we_ram[ch];
      if (mem_if.Mout_oe_ram[ch] && mem_if.Mout_we_ram[ch]) viol_cnt++;
      if (on && (a < win_lo || a >= win_lo + 32'd128)) viol_cnt++;
      if (mem_if.Mout_data_ram_size[ch*5 +: 5] != (on ? 5'd16 : 5'd0)) viol_cnt++;
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q[$];
  int src[64];
  int rb[64];
  int ref_out[64];

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  task automatic check_block(input string tag, input logic [31:0] base);
    for (int i = 0; i < 64; i++) begin
      logic [15:0] e;
      logic [15:0] a;
      e = exp_q.pop_front();
      a = mem[base[8:1] + 8'(i)];
      check($sformatf("%s_elem%0d", tag, i), int'($signed(a)), int'($signed(e)));
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_oe"},    int'(mem_if.Mout_oe_ram), 0);
    check({tag, "_we"},    int'(mem_if.Mout_we_ram), 0);
    check({tag, "_addr0"}, int'(mem_if.Mout_addr_ram[31:0]), 0);
    check({tag, "_addr1"}, int'(mem_if.Mout_addr_ram[63:32]), 0);
    check({tag, "_wdata"}, int'(mem_if.Mout_Wdata_ram), 0);
    check({tag, "_size"},  int'(mem_if.Mout_data_ram_size), 0);
    check({tag, "_done"},  int'(done_port), 0);
    check({tag, "_state"}, int'(mem_if.dbg_state), int'(IDLE));
  endtask

  // ---------------- reference model (integer C algorithm) ----------------
  function automatic int s16(input int v);
    logic [15:0] t;
    t = v[15:0];
    return int'($signed(t));
  endfunction

  function automatic int iclp(input int v);
    return (v < -256) ? -256 : ((v > 255) ? 255 : v);
  endfunction

  task automatic ref_model();
    int x0, x1, x2, x3, x4, x5, x6, x7, x8;
    for (int r = 0; r < 8; r++) begin
      int o;
      o = 8 * r;
      x1 = rb[o+4] <<< 11; x2 = rb[o+6]; x3 = rb[o+2]; x4 = rb[o+1];
      x5 = rb[o+7]; x6 = rb[o+5]; x7 = rb[o+3];
      if ((x1 | x2 | x3 | x4 | x5 | x6 | x7) == 0) begin
        x0 = s16(rb[o] <<< 3);
        for (int k = 0; k < 8; k++) rb[o+k] = x0;
      end else begin
        x0 = (rb[o] <<< 11) + 128;
        x8 = 565 * (x4 + x5); x4 = x8 + 2276 * x4; x5 = x8 - 3406 * x5;
        x8 = 2408 * (x6 + x7); x6 = x8 - 799 * x6; x7 = x8 - 4017 * x7;
        x8 = x0 + x1; x0 = x0 - x1;
        x1 = 1108 * (x3 + x2); x2 = x1 - 3784 * x2; x3 = x1 + 1568 * x3;
        x1 = x4 + x6; x4 = x4 - x6; x6 = x5 + x7; x5 = x5 - x7;
        x7 = x8 + x3; x8 = x8 - x3; x3 = x0 + x2; x0 = x0 - x2;
        x2 = (181 * (x4 + x5) + 128) >>> 8; x4 = (181 * (x4 - x5) + 128) >>> 8;
        rb[o+0] = s16((x7 + x1) >>> 8); rb[o+1] = s16((x3 + x2) >>> 8);
        rb[o+2] = s16((x0 + x4) >>> 8); rb[o+3] = s16((x8 + x6) >>> 8);
        rb[o+4] = s16((x8 - x6) >>> 8); rb[o+5] = s16((x0 - x4) >>> 8);
        rb[o+6] = s16((x3 - x2) >>> 8); rb[o+7] = s16((x7 - x1) >>> 8);
      end
    end
    for (int c = 0; c < 8; c++) begin
      x1 = rb[c+32] <<< 8; x2 = rb[c+48]; x3 = rb[c+16]; x4 = rb[c+8];
      x5 = rb[c+56]; x6 = rb[c+40]; x7 = rb[c+24];
      if ((x1 | x2 | x3 | x4 | x5 | x6 | x7) == 0) begin
        x0 = iclp((rb[c] + 32) >>> 6);
        for (int k = 0; k < 8; k++) rb[c+8*k] = x0;
      end else begin
        x0 = (rb[c] <<< 8) + 8192;
        x8 = 565 * (x4 + x5) + 4; x4 = (x8 + 2276 * x4) >>> 3; x5 = (x8 - 3406 * x5) >>> 3;
        x8 = 2408 * (x6 + x7) + 4; x6 = (x8 - 799 * x6) >>> 3; x7 = (x8 - 4017 * x7) >>> 3;
        x8 = x0 + x1; x0 = x0 - x1;
        x1 = 1108 * (x3 + x2) + 4; x2 = (x1 - 3784 * x2) >>> 3; x3 = (x1 + 1568 * x3) >>> 3;
        x1 = x4 + x6; x4 = x4 - x6; x6 = x5 + x7; x5 = x5 - x7;
        x7 = x8 + x3; x8 = x8 - x3; x3 = x0 + x2; x0 = x0 - x2;
        x2 = (181 * (x4 + x5) + 128) >>> 8; x4 = (181 * (x4 - x5) + 128) >>> 8;
        rb[c]    = iclp((x7 + x1) >>> 14); rb[c+8]  = iclp((x3 + x2) >>> 14);
        rb[c+16] = iclp((x0 + x4) >>> 14); rb[c+24] = iclp((x8 + x6) >>> 14);
        rb[c+32] = iclp((x8 - x6) >>> 14); rb[c+40] = iclp((x0 - x4) >>> 14);
        rb[c+48] = iclp((x3 - x2) >>> 14); rb[c+56] = iclp((x7 - x1) >>> 14);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_src(input logic [31:0] base);
    for (int i = 0; i < 64; i++) begin
      int v;
      @(negedge clock);
      v = src[i];
      ld_en   = 1'b1;
      ld_addr = base[8:1] + 8'(i);
      ld_data = v[15:0];
    end
    @(negedge clock);
    ld_en = 1'b0;
  endtask

  task automatic push_ref();
    for (int i = 0; i < 64; i++) begin
      int v;
      v = ref_out[i];
      exp_q.push_back(v[15:0]);
    end
  endtask

  task automatic run_and_check(input string tag, input logic [31:0] base,
                               input bit poke, input bit check_lat);
    int cyc, d0, v0;
    d0 = done_cnt;
    v0 = viol_cnt;
    win_lo = base;
    @(negedge clock);
    block = base;
    start_port = 1'b1;
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
      if (poke && cyc == 40) begin start_port = 1'b1; block = 32'h0; end
      else begin start_port = 1'b0; block = base; end
    end while (!done_port && cyc < 3000);
    check({tag, "_done_seen"}, int'(done_port), 1);
    if (check_lat) check({tag, "_latency_le_400"}, int'(cyc <= 400), 1);
    @(negedge clock);
    check({tag, "_back_idle"}, int'(mem_if.dbg_state), int'(IDLE));
    repeat (2) @(negedge clock);
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    check({tag, "_bus_viol"}, viol_cnt - v0, 0);
    check_block(tag, base);
  endtask

  // ---------------- test sequence ----------------
  typedef struct {
    int dc;
    int expected;
  } dc_vec_t;

  dc_vec_t dc_tab[4];

  initial begin
    int head[8];
    int n;
    dc_tab[0] = '{dc: -240,  expected: -30};
    dc_tab[1] = '{dc: 8,     expected: 1};
    dc_tab[2] = '{dc: 2047,  expected: 255};
    dc_tab[3] = '{dc: -2048, expected: -256};
    head = '{-240, 8, -11, 47, 26, -6, 0, 5};

    repeat (3) @(negedge clock);
    check_quiet("reset");
    reset = 1'b1;
    @(negedge clock);
    check_quiet("post_reset");

    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 64; i++) src[i] = 0;
      src[0] = dc_tab[t].dc;
      load_src(32'h0);
      for (int i = 0; i < 64; i++) begin
        int v;
        v = dc_tab[t].expected;
        exp_q.push_back(v[15:0]);
      end
      run_and_check($sformatf("dc%0d", t), 32'h0, 1'b0, 1'b1);
    end

    // Full vector; row 5 carries only a DC term to exercise the all-zero-AC case.
    for (int i = 0; i < 64; i++) begin
      src[i] = ((i * 29) % 23) - 11;
      if (i > 40 && i < 48) src[i] = 0;
      if (i < 8) src[i] = head[i];
    end
    rb = src;
    ref_model();
    ref_out = rb;

    load_src(32'h0);
    push_ref();
    run_and_check("full", 32'h0, 1'b0, 1'b1);

    rand_wait = 1'b1;
    load_src(32'h100);
    push_ref();
    run_and_check("wait", 32'h100, 1'b1, 1'b0);
    rand_wait = 1'b0;

    load_src(32'h0);
    win_lo = 32'h0;
    @(negedge clock);
    block = 32'h0;
    start_port = 1'b1;
    @(negedge clock);
    start_port = 1'b0;
    n = 0;
    while (mem_if.dbg_state != ROW_WRITE && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("abort_reach_row_write", int'(mem_if.dbg_state), int'(ROW_WRITE));
    reset = 1'b0;
    #1;
    check_quiet("abort");
    @(negedge clock);
    reset = 1'b1;
    load_src(32'h0);
    push_ref();
    run_and_check("rerun", 32'h0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
